// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage divider: FSM encoding, step count,
// operation decode values and sign helpers.
package div_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_W     = 32;
    localparam int DIV_STEPS = 32;

    // EX-stage operation codes; DIV/DIVU sit beside the existing ALU codes.
    localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
    localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    function automatic logic [DIV_W-1:0] mag32(input logic [DIV_W-1:0] v, input logic sgn);
        return (sgn && v[DIV_W-1]) ? -v : v;
    endfunction

    function automatic logic [DIV_W-1:0] apply_sign(input logic [DIV_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Handshake and operand/result bundle between the EX stage and the divider.
interface div_unit_if;
    import div_unit_pkg::*;

    logic             start;
    logic             is_signed;
    logic             annul;
    logic [DIV_W-1:0] dividend;
    logic [DIV_W-1:0] divisor;
    logic             busy;
    logic             done;
    logic [DIV_W-1:0] quotient;
    logic [DIV_W-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, annul, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, annul, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_unit_step.sv
// One restoring division iteration on the combined {rem,quo} register.
module div_step
    import div_unit_pkg::*;
(
    input  logic [2*DIV_W-1:0] rq_i,
    input  logic [DIV_W-1:0]   dvs_i,
    output logic [2*DIV_W-1:0] rq_o
);

    logic [DIV_W:0] trial;

    // rem < divisor is invariant, so the shifted remainder fits in 33 bits and
    // a kept difference always fits back into 32.
    always_comb begin
        trial = rq_i[2*DIV_W-1:DIV_W-1] - {1'b0, dvs_i};
        if (!trial[DIV_W]) begin
            rq_o = {trial[DIV_W-1:0], rq_i[DIV_W-2:0], 1'b1};
        end else begin
            rq_o = {rq_i[2*DIV_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-step radix-2 divider for DIV/DIVU with pipeline stall request
// and flush (annul) support.
module div_unit
    import div_unit_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    div_unit_if.slave  div_if
);

    div_state_e         state_q;
    logic [5:0]         cnt_q;
    logic [2*DIV_W-1:0] rq_q;
    logic [2*DIV_W-1:0] rq_step;
    logic [DIV_W-1:0]   dvs_q;
    logic               qneg_q;
    logic               rneg_q;
    logic               done_q;
    logic [DIV_W-1:0]   quo_q;
    logic [DIV_W-1:0]   rem_q;
    logic               dbz_q;

    logic accept;
    logic dvs_zero;

    assign dvs_zero = (div_if.divisor == '0);
    assign accept   = (state_q == IDLE) && div_if.start && !div_if.annul;

    div_step u_step (
        .rq_i  (rq_q),
        .dvs_i (dvs_q),
        .rq_o  (rq_step)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (dvs_zero) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            quo_q   <= '1;
                            rem_q   <= div_if.dividend;
                            dbz_q   <= 1'b1;
                        end else begin
                            state_q <= CALC;
                            cnt_q   <= '0;
                            qneg_q  <= div_if.is_signed & (div_if.dividend[DIV_W-1] ^ div_if.divisor[DIV_W-1]);
                            rneg_q  <= div_if.is_signed & div_if.dividend[DIV_W-1];
                        end
                    end
                end
                CALC: begin
                    if (div_if.annul) begin
                        state_q <= IDLE;
                    end else if (cnt_q == 6'(DIV_STEPS - 1)) begin
                        // Results are taken straight from the final step, so no extra cycle.
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        quo_q   <= apply_sign(rq_step[DIV_W-1:0], qneg_q);
                        rem_q   <= apply_sign(rq_step[2*DIV_W-1:DIV_W], rneg_q);
                        dbz_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Working datapath carries no reset; it is always reloaded on acceptance.
    always_ff @(posedge clk) begin
        if (accept && !dvs_zero) begin
            rq_q  <= {{DIV_W{1'b0}}, mag32(div_if.dividend, div_if.is_signed)};
            dvs_q <= mag32(div_if.divisor, div_if.is_signed);
        end else if (state_q == CALC) begin
            rq_q <= rq_step;
        end
    end

    assign div_if.busy        = (state_q == CALC) || (accept && !dvs_zero);
    assign div_if.done        = done_q;
    assign div_if.quotient    = quo_q;
    assign div_if.remainder   = rem_q;
    assign div_if.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, annul, reset and random
// DIV/DIVU traffic against an arithmetic reference model.
module tb_div_unit;
    import div_unit_pkg::*;

    logic clk = 1'b0;
    logic resetn;

    div_unit_if dif ();

    div_unit dut (
        .clk    (clk),
        .resetn (resetn),
        .div_if (dif)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;
    logic        last_z = 1'b0;

    // MIPS semantics: truncating division, remainder takes the dividend's sign.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit s,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            z  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    task automatic test_reset();
        resetn        = 1'b0;
        dif.start     = 1'b0;
        dif.is_signed = 1'b0;
        dif.annul     = 1'b0;
        dif.dividend  = '0;
        dif.divisor   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (dif.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", dif.busy); end
        vectors++; if (dif.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", dif.done); end
        vectors++; if (dif.quotient !== 32'd0) begin miscompares++; $display("FAIL reset_quo got %h want 0", dif.quotient); end
        vectors++; if (dif.remainder !== 32'd0) begin miscompares++; $display("FAIL reset_rem got %h want 0", dif.remainder); end
        vectors++; if (dif.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz got %b want 0", dif.div_by_zero); end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    // Starts at cycle 0 (just after an edge) and returns just after the edge
    // that ends the done cycle, with start still held.
    task automatic test_div(input logic [31:0] a, input logic [31:0] b, input bit s);
        logic [31:0] eq, er;
        logic        ez;
        int          dc;
        model(a, b, s, eq, er, ez);
        dc = (b == 32'd0) ? 1 : DIV_STEPS + 1;
        dif.dividend  = a;
        dif.divisor   = b;
        dif.is_signed = s;
        dif.annul     = 1'b0;
        dif.start     = 1'b1;
        for (int c = 0; c <= dc; c++) begin
            @(negedge clk);
            vectors++;
            if (dif.busy !== ((b != 32'd0) && (c < dc))) begin
                miscompares++;
                $display("FAIL div_busy %h/%h s=%0d cyc=%0d got %b want %b", a, b, s, c, dif.busy, (b != 32'd0) && (c < dc));
            end
            vectors++;
            if (dif.done !== (c == dc)) begin
                miscompares++;
                $display("FAIL div_done %h/%h s=%0d cyc=%0d got %b want %b", a, b, s, c, dif.done, c == dc);
            end
            if (c == dc) begin
                vectors++; if (dif.quotient !== eq) begin miscompares++; $display("FAIL div_quo %h/%h s=%0d got %h want %h", a, b, s, dif.quotient, eq); end
                vectors++; if (dif.remainder !== er) begin miscompares++; $display("FAIL div_rem %h/%h s=%0d got %h want %h", a, b, s, dif.remainder, er); end
                vectors++; if (dif.div_by_zero !== ez) begin miscompares++; $display("FAIL div_dbz %h/%h s=%0d got %b want %b", a, b, s, dif.div_by_zero, ez); end
            end
            @(posedge clk); #1;
        end
        last_q = eq;
        last_r = er;
        last_z = ez;
    endtask

    task automatic test_idle();
        dif.start = 1'b0;
        dif.annul = 1'b0;
        @(negedge clk);
        vectors++; if (dif.busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got %b want 0", dif.busy); end
        vectors++; if (dif.done !== 1'b0) begin miscompares++; $display("FAIL idle_done got %b want 0", dif.done); end
        vectors++; if (dif.quotient !== last_q) begin miscompares++; $display("FAIL idle_quo got %h want %h", dif.quotient, last_q); end
        vectors++; if (dif.remainder !== last_r) begin miscompares++; $display("FAIL idle_rem got %h want %h", dif.remainder, last_r); end
        vectors++; if (dif.div_by_zero !== last_z) begin miscompares++; $display("FAIL idle_dbz got %b want %b", dif.div_by_zero, last_z); end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        test_div(32'd100, 32'd7, 1'b0);               test_idle();
        test_div(32'hFFFF_FFF9, 32'd2, 1'b1);         test_idle();
        test_div(32'hFFFF_FFF9, 32'd2, 1'b0);         test_idle();
        test_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); test_idle();
        test_div(32'd5, 32'd0, 1'b0);                 test_idle();
        test_div(32'h8000_0005, 32'd0, 1'b1);         test_idle();
    endtask

    task automatic test_annul();
        logic [31:0] bz [2];
        test_div(32'd100, 32'd7, 1'b0);
        test_idle();
        dif.dividend  = 32'd50;
        dif.divisor   = 32'd3;
        dif.is_signed = 1'b0;
        dif.start     = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            if (c == 10) dif.annul = 1'b1;
            if (c == 11) begin dif.start = 1'b0; dif.annul = 1'b0; end
            @(negedge clk);
            vectors++; if (dif.busy !== (c <= 10)) begin miscompares++; $display("FAIL annul_busy cyc=%0d got %b want %b", c, dif.busy, c <= 10); end
            vectors++; if (dif.done !== 1'b0) begin miscompares++; $display("FAIL annul_done cyc=%0d got %b want 0", c, dif.done); end
            vectors++; if (dif.quotient !== 32'd14) begin miscompares++; $display("FAIL annul_quo cyc=%0d got %h want 14", c, dif.quotient); end
            vectors++; if (dif.remainder !== 32'd2) begin miscompares++; $display("FAIL annul_rem cyc=%0d got %h want 2", c, dif.remainder); end
            @(posedge clk); #1;
        end
        test_div(32'd50, 32'd3, 1'b0);
        test_idle();
        // A start that arrives together with annul in IDLE must be dropped.
        bz[0] = 32'd0;
        bz[1] = 32'd9;
        for (int k = 0; k < 2; k++) begin
            dif.dividend = 32'd77;
            dif.divisor  = bz[k];
            dif.start    = 1'b1;
            dif.annul    = 1'b1;
            @(negedge clk);
            vectors++; if (dif.busy !== 1'b0) begin miscompares++; $display("FAIL annul_idle_busy dvs=%0d got %b want 0", bz[k], dif.busy); end
            @(posedge clk); #1;
            test_idle();
        end
    endtask

    task automatic test_reset_mid();
        dif.dividend  = 32'd100;
        dif.divisor   = 32'd7;
        dif.is_signed = 1'b0;
        dif.annul     = 1'b0;
        dif.start     = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++; if (dif.busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy cyc=%0d got %b want 1", c, dif.busy); end
            @(posedge clk); #1;
        end
        resetn    = 1'b0;
        dif.start = 1'b0;
        #1;
        vectors++; if (dif.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy_async got %b want 0", dif.busy); end
        vectors++; if (dif.done !== 1'b0) begin miscompares++; $display("FAIL rstmid_done got %b want 0", dif.done); end
        vectors++; if (dif.quotient !== 32'd0) begin miscompares++; $display("FAIL rstmid_quo got %h want 0", dif.quotient); end
        vectors++; if (dif.remainder !== 32'd0) begin miscompares++; $display("FAIL rstmid_rem got %h want 0", dif.remainder); end
        vectors++; if (dif.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL rstmid_dbz got %b want 0", dif.div_by_zero); end
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        last_q = '0;
        last_r = '0;
        last_z = 1'b0;
        test_idle();
        test_div(32'd1000, 32'd7, 1'b0);
        test_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        bit          s;
        int          sel;
        for (int n = 0; n < 40; n++) begin
            a   = $urandom;
            b   = $urandom;
            s   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'd1;
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1'b1; end
                4: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            test_div(a, b, s);
            if ($urandom_range(0, 1) == 1) test_idle();
        end
        test_idle();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit radix-2 divider for MIPS DIV/DIVU, placed in the execute stage beside the single-cycle ALU. It takes the same rs/rt operands the ALU receives and produces quotient (LO) and remainder (HI) for the HI/LO write. While a division is in progress it raises a stall request that freezes the pipeline. It also supports an annul input so that an exception flush can abort an in-flight division.

## Interface
- No parameters; width fixed at 32, iteration count fixed at 32.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request a division. Sampled only in IDLE.
- is_signed  in  1  1 = DIV, 0 = DIVU. Sampled with start.
- annul  in  1  abort the current or requested division (pipeline flush).
- dividend  in  32  rs value. Sampled with start.
- divisor  in  32  rt value. Sampled with start.
- busy  out  1  stall request to the pipeline.
- done  out  1  one-cycle pulse; results valid.
- quotient  out  32  to LO.
- remainder  out  32  to HI.
- div_by_zero  out  1  divisor was 0 for the most recent completed division.

## Operation
- States:
  - IDLE: waiting for start.
  - CALC: 32 restoring steps.
  - DONE: one cycle, results presented.
- Transitions:
  - IDLE → CALC on start & ~annul & divisor≠0.
  - IDLE → DONE on start & ~annul & divisor==0.
  - CALC → DONE when the step counter reaches 31.
  - CALC → IDLE on annul.
  - DONE → IDLE unconditionally.
- Start acceptance:
  - On acceptance, latch |dividend| and |divisor| (magnitudes when is_signed, raw values otherwise).
  - Also latch the quotient sign = dividend[31]^divisor[31] and the remainder sign = dividend[31]. Both are forced to 0 when unsigned.
- Each CALC step:
  - Shift the 64-bit {rem,quo} register left by 1.
  - Trial-subtract the divisor magnitude from the upper 33 bits.
  - If the result is non-negative, keep the difference and set quo[0] = 1.
  - Step counter is 6 bits, 0..31.
- DONE outputs:
  - quotient and remainder are loaded from the magnitude results, negated per the latched signs. Truncate to 32 bits.
  - 0x80000000 / 0xFFFFFFFF (signed) → quotient 0x80000000, remainder 0. No trap.
- Divide by zero:
  - quotient = 0xFFFFFFFF, remainder = dividend (raw), div_by_zero = 1.
  - Otherwise div_by_zero = 0 on completion.
- start is ignored in CALC and DONE. The stalled instruction still holds start during DONE and must not retrigger.
- Annul:
  - annul in IDLE with start → start ignored.
  - annul in CALC → IDLE next edge; no done; outputs keep their previous values.
  - annul in DONE has no effect; the results are already presented.

## Timing
- Reset values: busy 0, done 0, quotient 0, remainder 0, div_by_zero 0, state IDLE, counter 0.
- Reset takes effect immediately, including mid-CALC.
- busy is combinational: (state==CALC) | (state==IDLE & start & ~annul & divisor≠0). The EX stage therefore stalls in the start cycle itself.
- busy is 0 in DONE, so the pipeline advances in the cycle that done is high.
- Latency for a normal division:
  - start cycle = cycle 0.
  - CALC occupies cycles 1..32; done = 1 in cycle 33.
  - busy is high in cycles 0..32.
- Latency for divide by zero: done = 1 in cycle 1; busy never asserts.
- done is registered and lasts exactly one cycle.
- quotient, remainder and div_by_zero are registered. They hold until the next completion or reset.
- Back-to-back divisions: a start in the cycle after DONE (IDLE) is accepted normally.

## Structure
- Shared package / defines header:
  - state encoding (IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2);
  - DIV_STEPS = 32;
  - EXE_DIV_OP and EXE_DIVU_OP decode values, alongside the existing EXE_*_OP codes.
- One combinational sub-module, div_step: one restoring iteration.
  - Inputs: 64-bit {rem,quo} and the 32-bit divisor magnitude.
  - Output: next 64-bit {rem,quo}.
- Sign handling, FSM and output registers live in div_unit.

## Test plan
- DIVU 100/7, start in cycle 0 → busy high in cycles 0..32; done in cycle 33 only; quotient 14, remainder 2, div_by_zero 0.
- DIV 0xFFFFFFF9/2 (−7/2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Same operands as DIVU → quotient 0x7FFFFFFC, remainder 1.
- DIV 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0, no hang, done in cycle 33.
- DIVU 5/0 → busy stays 0; done in cycle 1; quotient 0xFFFFFFFF, remainder 5, div_by_zero 1.
- After a completed 100/7, start 50/3 and assert annul in cycle 10:
  - busy 0 from cycle 11; no done;
  - outputs still read 14/2;
  - a new start in cycle 12 completes in cycle 45 with 16/2.
- resetn low in cycle 5 of a division → immediately busy 0, done 0, quotient/remainder 0. After release, start is accepted and completes normally.
